// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector:
// default sizes, detector sub-state type, and length clamp/mask helpers.
package seq_det_pkg;

    localparam int MAX_W_DEF = 8;
    localparam int LEN_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        ST_FILLING = 1'b0,
        ST_ARMED   = 1'b1
    } fill_state_e;

    // A zero length would never match, so it is promoted to a single bit.
    function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] max_w);
        logic [31:0] res;
        if (len == 32'd0) begin
            res = 32'd1;
        end else if (len > max_w) begin
            res = max_w;
        end else begin
            res = len;
        end
        return res;
    endfunction

    function automatic logic [31:0] mask_from_len(input logic [31:0] len);
        logic [31:0] res;
        res = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (32'(i) < len) begin
                res[i] = 1'b1;
            end else begin
                res[i] = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the counter at one so that event is not lost.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_arstn,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_n;

    // Next count: clear has priority, increment stops at all-ones.
    always_comb begin
        w_count_n = r_count;
        if (i_clr) begin
            if (i_inc) begin
                w_count_n = CNT_ONE;
            end else begin
                w_count_n = {CNT_W{1'b0}};
            end
        end else if (i_inc && (r_count != CNT_MAX)) begin
            w_count_n = r_count + CNT_ONE;
        end else begin
            w_count_n = r_count;
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_count <= w_count_n;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a run-time programmable 1..MAX_W bit pattern,
// overlapping/non-overlapping modes and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               MAX_W       = MAX_W_DEF,
    parameter int               LEN_W       = LEN_W_DEF,
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [MAX_W-1:0] DEF_PATTERN = 8'b0000_0111,
    parameter logic [LEN_W-1:0] DEF_LEN     = 4'd3
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             en,
    input  logic             w,
    input  logic             overlap,
    input  logic             cfg_load,
    input  logic [MAX_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             clr_count,
    output logic             q,
    output logic [CNT_W-1:0] match_cnt,
    output logic [LEN_W-1:0] fill
);

    // The oldest history bit is never compared again, so only MAX_W-1 are kept.
    logic [MAX_W-2:0] r_hist;
    logic [MAX_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_fill;
    logic             r_q;

    logic [LEN_W-1:0] w_len_cl;
    logic [MAX_W-1:0] w_mask;
    logic [MAX_W-1:0] w_hist_n;
    logic [LEN_W-1:0] w_fill_n;
    fill_state_e      w_state_n;
    logic             w_hit;

    assign w_len_cl  = LEN_W'(clamp_len(32'(cfg_len), 32'(MAX_W)));
    assign w_mask    = MAX_W'(mask_from_len(32'(r_len)));
    assign w_hist_n  = {r_hist, w};
    assign w_fill_n  = (r_fill < r_len) ? (r_fill + LEN_W'(1'b1)) : r_len;
    assign w_state_n = (w_fill_n == r_len) ? ST_ARMED : ST_FILLING;
    assign w_hit     = en & ~cfg_load & (w_state_n == ST_ARMED)
                     & ~(|((w_hist_n ^ r_pat) & w_mask));

    // History, fill level, configuration and registered match pulse.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_hist <= {(MAX_W-1){1'b0}};
            r_fill <= {LEN_W{1'b0}};
            r_pat  <= DEF_PATTERN;
            r_len  <= DEF_LEN;
            r_q    <= 1'b0;
        end else if (cfg_load) begin
            r_hist <= {(MAX_W-1){1'b0}};
            r_fill <= {LEN_W{1'b0}};
            r_pat  <= cfg_pattern;
            r_len  <= w_len_cl;
            r_q    <= 1'b0;
        end else if (en) begin
            r_hist <= w_hist_n[MAX_W-2:0];
            r_fill <= (w_hit && !overlap) ? {LEN_W{1'b0}} : w_fill_n;
            r_q    <= w_hit;
        end else begin
            r_q    <= 1'b0;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .i_clk   (clk),
        .i_arstn (arstn),
        .i_inc   (w_hit),
        .i_clr   (clr_count),
        .o_count (match_cnt)
    );

    assign q    = r_q;
    assign fill = r_fill;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table, hand-written corner
// sequences, then random stimulus against a bit-queue reference model.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       arstn;
    logic       en, w, overlap, cfg_load, clr_count;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       q, q2;
    logic [7:0] match_cnt;
    logic [1:0] cnt2;
    logic [3:0] fill, fill2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.MAX_W(8), .LEN_W(4), .CNT_W(8)) u_dut (
        .clk(clk), .arstn(arstn), .en(en), .w(w), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .clr_count(clr_count), .q(q), .match_cnt(match_cnt), .fill(fill));

    seq_detector_param #(.MAX_W(8), .LEN_W(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .arstn(arstn), .en(en), .w(w), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .clr_count(clr_count), .q(q2), .match_cnt(cnt2), .fill(fill2));

    // Reference model: bits seen since the last (re)configuration, number of
    // fresh bits usable for the next match, and plain integer counters.
    bit         m_bits[$];
    int         m_fresh, m_len, m_cnt1, m_cnt2;
    logic [7:0] m_pat;
    bit         m_q;

    function automatic void model_reset();
        m_bits.delete();
        m_fresh = 0; m_len = 3; m_pat = 8'h07;
        m_cnt1 = 0; m_cnt2 = 0; m_q = 1'b0;
    endfunction

    function automatic void model_edge();
        bit hit = 1'b0;
        if (cfg_load) begin
            m_pat = cfg_pattern;
            m_len = (cfg_len == 4'd0) ? 1 : ((int'(cfg_len) > 8) ? 8 : int'(cfg_len));
            m_bits.delete();
            m_fresh = 0;
            m_q = 1'b0;
        end else if (en) begin
            m_bits.push_back(w);
            if (m_bits.size() > 8) void'(m_bits.pop_front());
            m_fresh++;
            hit = (m_fresh >= m_len);
            for (int i = 0; i < m_len; i++)
                if (hit && (m_bits[m_bits.size()-1-i] != m_pat[i])) hit = 1'b0;
            if (hit && !overlap) m_fresh = 0;
            m_q = hit;
        end else begin
            m_q = 1'b0;
        end
        if (clr_count) begin
            m_cnt1 = hit ? 1 : 0;
            m_cnt2 = hit ? 1 : 0;
        end else if (hit) begin
            m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
    endfunction

    function automatic int model_fill();
        return (m_fresh < m_len) ? m_fresh : m_len;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic e, input logic b, input logic ov, input logic ld,
                         input logic [7:0] pat, input logic [3:0] len, input logic clr);
        en = e; w = b; overlap = ov; cfg_load = ld;
        cfg_pattern = pat; cfg_len = len; clr_count = clr;
    endtask

    task automatic vstep(input string nm, input logic e, input logic b, input logic ov,
                         input logic ld, input logic [7:0] pat, input logic [3:0] len,
                         input logic clr, input logic eq, input int ecnt, input int efill);
        drive(e, b, ov, ld, pat, len, clr);
        tick();
        chk({nm, "_q"}, 32'(q), 32'(eq));
        chk({nm, "_cnt"}, 32'(match_cnt), 32'(ecnt));
        chk({nm, "_fill"}, 32'(fill), 32'(efill));
    endtask

    typedef struct {
        logic       en, w, ov, ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       clr;
        logic       eq;
        int         ecnt;
        int         efill;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic e, input logic b, input logic ov, input logic ld,
                                input logic [7:0] pat, input logic [3:0] len, input logic clr,
                                input logic eq, input int ecnt, input int efill);
        vec_t v;
        v.en = e; v.w = b; v.ov = ov; v.ld = ld; v.pat = pat; v.len = len;
        v.clr = clr; v.eq = eq; v.ecnt = ecnt; v.efill = efill;
        vecs.push_back(v);
    endfunction

    initial begin
        arstn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        model_reset();
        #12;
        arstn = 1'b1;
        chk("reset_q", 32'(q), 32'd0);
        chk("reset_cnt", 32'(match_cnt), 32'd0);
        chk("reset_fill", 32'(fill), 32'd0);

        // Default 111, overlapping: pulses on bits 3,4,5.
        add(1,1,1,0,8'h00,4'd0,0, 0,0,1);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,2);
        add(1,1,1,0,8'h00,4'd0,0, 1,1,3);
        add(1,1,1,0,8'h00,4'd0,0, 1,2,3);
        add(1,1,1,0,8'h00,4'd0,0, 1,3,3);
        add(0,0,0,1,8'h07,4'd3,1, 0,0,0);
        // Default 111, non-overlapping: pulses on bits 3 and 6.
        add(1,1,0,0,8'h00,4'd0,0, 0,0,1);
        add(1,1,0,0,8'h00,4'd0,0, 0,0,2);
        add(1,1,0,0,8'h00,4'd0,0, 1,1,0);
        add(1,1,0,0,8'h00,4'd0,0, 0,1,1);
        add(1,1,0,0,8'h00,4'd0,0, 0,1,2);
        add(1,1,0,0,8'h00,4'd0,0, 1,2,0);
        // Pattern 1011, overlapping, stream 1011011.
        add(0,0,1,1,8'h0B,4'd4,1, 0,0,0);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,1);
        add(1,0,1,0,8'h00,4'd0,0, 0,0,2);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,3);
        add(1,1,1,0,8'h00,4'd0,0, 1,1,4);
        add(1,0,1,0,8'h00,4'd0,0, 0,1,4);
        add(1,1,1,0,8'h00,4'd0,0, 0,1,4);
        add(1,1,1,0,8'h00,4'd0,0, 1,2,4);
        // Same stream non-overlapping: only the first match.
        add(0,0,0,1,8'h0B,4'd4,1, 0,0,0);
        add(1,1,0,0,8'h00,4'd0,0, 0,0,1);
        add(1,0,0,0,8'h00,4'd0,0, 0,0,2);
        add(1,1,0,0,8'h00,4'd0,0, 0,0,3);
        add(1,1,0,0,8'h00,4'd0,0, 1,1,0);
        add(1,0,0,0,8'h00,4'd0,0, 0,1,1);
        add(1,1,0,0,8'h00,4'd0,0, 0,1,2);
        add(1,1,0,0,8'h00,4'd0,0, 0,1,3);
        // en gap in the middle of 111.
        add(0,0,1,1,8'h07,4'd3,1, 0,0,0);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,1);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,2);
        add(0,0,1,0,8'h00,4'd0,0, 0,0,2);
        add(0,1,1,0,8'h00,4'd0,0, 0,0,2);
        add(0,0,1,0,8'h00,4'd0,0, 0,0,2);
        add(1,1,1,0,8'h00,4'd0,0, 1,1,3);
        add(0,0,1,0,8'h00,4'd0,0, 0,1,3);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].w, vecs[i].ov, vecs[i].ld,
                  vecs[i].pat, vecs[i].len, vecs[i].clr);
            tick();
            chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].eq));
            chk($sformatf("vec%0d_cnt", i), 32'(match_cnt), 32'(vecs[i].ecnt));
            chk($sformatf("vec%0d_fill", i), 32'(fill), 32'(vecs[i].efill));
        end

        // Mid-stream async reset restores the default 111 pattern.
        vstep("rst_cfg", 0,0,1,1,8'h05,4'd3,0, 0,1,0);
        vstep("rst_b1", 1,1,1,0,8'h00,4'd0,0, 0,1,1);
        vstep("rst_b2", 1,1,1,0,8'h00,4'd0,0, 0,1,2);
        @(negedge clk);
        arstn = 1'b0;
        model_reset();
        #1;
        chk("rst_in_q", 32'(q), 32'd0);
        chk("rst_in_cnt", 32'(match_cnt), 32'd0);
        chk("rst_in_fill", 32'(fill), 32'd0);
        #1;
        arstn = 1'b1;
        vstep("post_b1", 1,1,1,0,8'h00,4'd0,0, 0,0,1);
        vstep("post_b2", 1,1,1,0,8'h00,4'd0,0, 0,0,2);
        vstep("post_b3", 1,1,1,0,8'h00,4'd0,0, 1,1,3);

        // Saturation of the 2-bit counter and clear/hit priority.
        vstep("sat_cfg", 0,0,1,1,8'h07,4'd3,1, 0,0,0);
        vstep("sat_b1", 1,1,1,0,8'h00,4'd0,0, 0,0,1);
        vstep("sat_b2", 1,1,1,0,8'h00,4'd0,0, 0,0,2);
        for (int k = 1; k <= 5; k++)
            vstep($sformatf("sat_hit%0d", k), 1,1,1,0,8'h00,4'd0,0, 1,k,3);
        chk("sat_cnt2", 32'(cnt2), 32'd3);
        vstep("clr_hit", 1,1,1,0,8'h00,4'd0,1, 1,1,3);
        chk("clr_hit_cnt2", 32'(cnt2), 32'd1);
        vstep("clr_nohit", 0,0,1,0,8'h00,4'd0,1, 0,0,3);
        chk("clr_nohit_cnt2", 32'(cnt2), 32'd0);

        // Length 0 clamps to 1: every qualified 1 matches.
        vstep("len0_cfg", 0,0,0,1,8'h01,4'd0,0, 0,0,0);
        vstep("len0_b1", 1,1,0,0,8'h00,4'd0,0, 1,1,0);
        vstep("len0_b0", 1,0,0,0,8'h00,4'd0,0, 0,1,1);
        vstep("len0_b1b", 1,1,0,0,8'h00,4'd0,0, 1,2,0);
        vstep("len15_cfg", 0,0,1,1,8'hFF,4'd15,0, 0,2,0);

        // Random traffic against the reference model.
        overlap = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            en = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) overlap = ~overlap;
            cfg_load = ($urandom_range(0, 63) == 0);
            cfg_pattern = 8'($urandom);
            cfg_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(1, 4));
            clr_count = ($urandom_range(0, 99) == 0);
            tick();
            chk("rnd_q", 32'(q), 32'(m_q));
            chk("rnd_cnt", 32'(match_cnt), 32'(m_cnt1));
            chk("rnd_fill", 32'(fill), 32'(model_fill()));
            chk("rnd_q2", 32'(q2), 32'(m_q));
            chk("rnd_cnt2", 32'(cnt2), 32'(m_cnt2));
            chk("rnd_fill2", 32'(fill2), 32'(model_fill()));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
